inst_axi_rd_bridge: RTL
=======================

INST_AXI_RD_BRIDGE -- requirements
Module: inst_axi_rd_bridge

Interface
REQ-001 SHALL have parameter OST_DEPTH, default 2, the maximum number of outstanding AXI reads (1..7).
REQ-002 SHALL have parameter ARID_VAL, default 4'h0, the constant arid driven on every read.
REQ-003 SHALL have port clk input 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset input 1: reset, asynchronous, active-high.
REQ-005 SHALL have port inst_sram_req input 1: fetch request from IF.
REQ-006 SHALL have port inst_sram_wr input 1: write flag; always 0 from IF.
REQ-007 SHALL have port inst_sram_size input 2: log2 of byte count.
REQ-008 SHALL have port inst_sram_addr input 32: fetch address.
REQ-009 SHALL have port inst_sram_addr_ok output 1: request accepted.
REQ-010 SHALL have port inst_sram_data_ok output 1: instruction returned.
REQ-011 SHALL have port inst_sram_rdata output 32: instruction word.
REQ-012 SHALL have port fs_cancel input 1: one-cycle pulse from IF on exception, ertn or redirect; discards all older outstanding responses.
REQ-013 SHALL have AXI AR master ports: arid out 4, araddr out 32, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1.
REQ-014 SHALL have AXI R master ports: rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.

Function
REQ-015 SHALL implement AR FSM with states AR_IDLE and AR_BUSY.
REQ-016 SHALL assert inst_sram_addr_ok combinationally when state==AR_IDLE, req=1, wr=0, ost_cnt<OST_DEPTH.
REQ-017 SHALL never assert addr_ok for wr=1; such requests stall forever.
REQ-018 SHALL, on addr_ok, latch addr into araddr and {1'b0,size} into arsize, move to AR_BUSY, and assert arvalid from the next cycle.
REQ-019 SHALL hold arvalid and araddr stable in AR_BUSY until arready, then return to AR_IDLE; a new accept is possible in the cycle after the handshake.
REQ-020 SHALL drive arid=ARID_VAL, arlen=0, arburst=2'b01 constantly; arvalid SHALL NOT depend combinationally on arready.
REQ-021 SHALL drive rready=1 at all times after reset release.
REQ-022 SHALL keep ost_cnt: +1 on addr_ok, -1 on R handshake, unchanged when both occur in one cycle; never exceeds OST_DEPTH, never underflows.
REQ-023 SHALL keep disc_cnt: on fs_cancel load ost_cnt minus 1 if an R handshake occurs that cycle; otherwise -1 on each R handshake while non-zero.
REQ-024 SHALL NOT count a request accepted in the fs_cancel cycle into disc_cnt; it is the redirect fetch.
REQ-025 SHALL discard (no data_ok) any R handshake occurring while disc_cnt>0 or fs_cancel=1.
REQ-026 SHALL otherwise assert data_ok with rdata passed to inst_sram_rdata, responses in issue order.
REQ-027 SHALL ignore rresp and rid for data return; a non-OKAY response is returned as normal data.
REQ-028 SHALL let fs_cancel leave the AR FSM unaffected: a pending arvalid still completes.

Reset
REQ-029 SHALL on reset force state=AR_IDLE, arvalid=0, araddr=0, arsize=0, ost_cnt=0, disc_cnt=0, rready=0, data_ok=0, rdata=0, addr_ok=0.
REQ-030 SHALL, when reset asserts mid-transaction, drop all outstanding reads; the system resets the AXI slave concurrently.

Configuration
REQ-031 SHALL honour macro INST_BRIDGE_RBUF_EN; when defined, R data is registered: data_ok and rdata appear one cycle after the accepted R handshake, and fs_cancel in that cycle clears the buffered data_ok.
REQ-032 SHALL, without INST_BRIDGE_RBUF_EN, produce data_ok/rdata combinationally in the same cycle as rvalid.

Verification
REQ-033 Single fetch: req, addr=0x1c000000, arready=1 immediately, rvalid 2 cycles later, rdata=0x02800c21 -> addr_ok in cycle 0, arvalid in cycle 1, data_ok with 0x02800c21 (next cycle if RBUF_EN).
REQ-034 Back-pressure: arready low for 3 cycles -> arvalid and araddr stable, addr_ok=0 throughout, one handshake only.
REQ-035 Depth limit: OST_DEPTH=2, three back-to-back reqs, no R -> two addr_ok, third held until first R handshake.
REQ-036 Cancel: two outstanding, fs_cancel with new req at 0x1c000008 -> first two responses give no data_ok, third gives data_ok.
REQ-037 Cancel coinciding with R handshake of one of two outstanding -> that response and the next are dropped, disc_cnt ends at 0.
REQ-038 Async reset asserted while arvalid=1 -> arvalid, counters and data_ok go 0 immediately without waiting for clk.

Source files
------------

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: converts IF-stage instruction SRAM-style fetches into
// single-beat AXI reads. Up to OST_DEPTH reads may be outstanding; fs_cancel
// discards the responses of every read issued before the cancel.
// Optional macro INST_BRIDGE_RBUF_EN registers the R data path, so data_ok
// and rdata appear one cycle after the accepted R handshake.
module inst_axi_rd_bridge #(
    parameter int         OST_DEPTH = 2,
    parameter logic [3:0] ARID_VAL  = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    // IF-side SRAM-like interface
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        fs_cancel,
    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;

    localparam logic [2:0] DEPTH = 3'(OST_DEPTH);

    ar_state_t   state, state_next;
    logic        accept;
    logic        rready_q;
    logic        r_hs;
    logic        r_dec;
    logic        discard;
    logic [2:0]  ost_cnt;
    logic [2:0]  disc_cnt;
    logic [31:0] araddr_q;
    logic [2:0]  arsize_q;

    // Responses are returned in issue order, so rid/rresp/rlast carry no information we need.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast};

    // AR state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= AR_IDLE;
        else       state <= state_next;
    end

    // AR next-state and request acceptance; rready_q gates acceptance while reset is held.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            AR_IDLE: begin
                if (inst_sram_req && !inst_sram_wr && (ost_cnt < DEPTH) && rready_q) begin
                    accept     = 1'b1;
                    state_next = AR_BUSY;
                end
            end
            AR_BUSY: begin
                if (arready) state_next = AR_IDLE;
            end
            default: state_next = AR_IDLE;
        endcase
    end

    // Capture the request attributes on acceptance and hold them until the AR handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            araddr_q <= 32'h0;
            arsize_q <= 3'h0;
        end else if (accept) begin
            araddr_q <= inst_sram_addr;
            arsize_q <= {1'b0, inst_sram_size};
        end
    end

    // rready is held low during reset and high forever afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rready_q <= 1'b0;
        else       rready_q <= 1'b1;
    end

    assign r_hs    = rvalid && rready_q;
    assign r_dec   = r_hs && (ost_cnt != 3'd0);
    assign discard = fs_cancel || (disc_cnt != 3'd0);

    // Outstanding-read counter; a simultaneous accept and response cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ost_cnt <= 3'd0;
        end else begin
            case ({accept, r_dec})
                2'b10:   ost_cnt <= ost_cnt + 3'd1;
                2'b01:   ost_cnt <= ost_cnt - 3'd1;
                default: ost_cnt <= ost_cnt;
            endcase
        end
    end

    // Discard counter: on cancel, every read already outstanding must be dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disc_cnt <= 3'd0;
        end else if (fs_cancel) begin
            disc_cnt <= r_dec ? (ost_cnt - 3'd1) : ost_cnt;
        end else if (r_hs && (disc_cnt != 3'd0)) begin
            disc_cnt <= disc_cnt - 3'd1;
        end
    end

`ifdef INST_BRIDGE_RBUF_EN
    logic        dok_q;
    logic [31:0] rdata_q;

    // Buffer accepted response data for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dok_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            dok_q <= r_hs && !discard;
            if (r_hs && !discard) rdata_q <= rdata;
        end
    end

    assign inst_sram_data_ok = dok_q && !fs_cancel;
    assign inst_sram_rdata   = inst_sram_data_ok ? rdata_q : 32'h0;
`else
    assign inst_sram_data_ok = r_hs && !discard;
    assign inst_sram_rdata   = inst_sram_data_ok ? rdata : 32'h0;
`endif

    assign inst_sram_addr_ok = accept;
    assign arid    = ARID_VAL;
    assign araddr  = araddr_q;
    assign arlen   = 8'h00;
    assign arsize  = arsize_q;
    assign arburst = 2'b01;
    assign arvalid = (state == AR_BUSY);
    assign rready  = rready_q;

endmodule
